fios_res_collect: RTL and testbench

Result collector and final-subtraction stage directly downstream of the folded FIOS Montgomery multiplier. It captures the s+1 17-bit result blocks pushed by the last active PE, least-significant first. It then conditionally subtracts the modulus n, reading n blocks from operand memory, and streams the reduced result out over a ready/valid handshake. The result is guaranteed to lie in [0, n).

---
 rtl/fios_pkg.sv | 13 +
 rtl/fios_res_collect_if.sv | 31 +++
 rtl/fios_res_collect_blk_sub.sv | 17 +
 rtl/fios_res_collect.sv | 205 ++++++++++++++++++++
 tb/tb_fios_res_collect.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fios_pkg.sv
// Shared types for the FIOS result collector: block width, block type and FSM states.
package fios_pkg;
  localparam int BLK_W = 17;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SUB     = 2'd2,
    OUT     = 2'd3
  } state_e;
endpackage

// File: rtl/fios_res_collect_if.sv
// Bus bundle of the result collector: FIOS push side, modulus read port and output stream.
interface fios_res_collect_if
  import fios_pkg::*;
#(
  parameter int s = 16
);
  localparam int AW = $clog2(s + 1);

  blk_t          res_i;
  logic          res_push_i;
  logic          last_i;
  logic [AW-1:0] n_addr_o;
  logic          n_rd_o;
  blk_t          n_i;
  blk_t          out_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          out_last_o;

  // collector side
  modport slave (
    input  res_i, res_push_i, last_i, n_i, out_ready_i,
    output n_addr_o, n_rd_o, out_o, out_valid_o, out_last_o
  );

  // environment side: FIOS array, operand memory and result consumer
  modport master (
    output res_i, res_push_i, last_i, n_i, out_ready_i,
    input  n_addr_o, n_rd_o, out_o, out_valid_o, out_last_o
  );
endinterface

// File: rtl/fios_res_collect_blk_sub.sv
// One 17-bit block of the final subtraction: diff = minuend - subtrahend - borrow_in.
module blk_sub
  import fios_pkg::*;
(
  input  blk_t minuend,
  input  blk_t subtrahend,
  input  logic borrow_in,
  output blk_t diff,
  output logic borrow_out
);
  logic [BLK_W:0] wide_s;

  // one extra bit so the borrow appears as the MSB of the wrapped difference
  assign wide_s     = {1'b0, minuend} - {1'b0, subtrahend} - {{BLK_W{1'b0}}, borrow_in};
  assign diff       = wide_s[BLK_W-1:0];
  assign borrow_out = wide_s[BLK_W];
endmodule

// File: rtl/fios_res_collect.sv
// Captures the s+1 FIOS result blocks, subtracts the modulus once if P >= n,
// and streams the reduced result out LS block first.
module fios_res_collect
  import fios_pkg::*;
#(
  parameter int s = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  fios_res_collect_if.slave bus,
  output logic              busy_o,
  output logic              err_o
);
  localparam int AW = $clog2(s + 1);
  localparam int CW = $clog2(s + 2);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_S    = CW'(s);
  localparam logic [CW-1:0] CNT_S1   = CW'(s + 1);

  state_e        state_r, state_nx_s;
  logic [CW-1:0] wcnt_r, wcnt_nx_s, k_r, k_nx_s, rcnt_r, rcnt_nx_s;
  logic          last_seen_r, last_seen_nx_s;
  logic          borrow_r, borrow_nx_s, sel_r, sel_nx_s, err_r, err_nx_s;

  blk_t          p_mem_r [s+1];
  blk_t          d_mem_r [s+1];
  logic          p_we_s, d_we_s;
  logic [CW-1:0] p_waddr_s, sub_idx_s;
  blk_t          nb_s, diff_s;
  logic          bout_s;

  logic [AW-1:0] n_addr_r, n_addr_nx_s;
  logic          n_rd_r, n_rd_nx_s;
  blk_t          out_r, out_nx_s;
  logic          out_valid_r, out_valid_nx_s, out_last_r, out_last_nx_s;
  logic          busy_r, busy_nx_s;
  logic          hs_s;

  assign hs_s = out_valid_r & bus.out_ready_i;

  // k = 0 only primes the modulus read; block k-1 is reduced from k = 1 on, the top block against 0
  assign sub_idx_s = (k_r == CNT_ZERO) ? CNT_ZERO : (k_r - CNT_ONE);
  assign nb_s      = (k_r == CNT_S1) ? {BLK_W{1'b0}} : bus.n_i;

  blk_sub u_blk_sub (
    .minuend    (p_mem_r[sub_idx_s]),
    .subtrahend (nb_s),
    .borrow_in  (borrow_r),
    .diff       (diff_s),
    .borrow_out (bout_s)
  );

  // next-state, counters, error and buffer write enables
  always_comb begin
    state_nx_s     = state_r;
    wcnt_nx_s      = wcnt_r;
    k_nx_s         = k_r;
    rcnt_nx_s      = rcnt_r;
    last_seen_nx_s = last_seen_r;
    borrow_nx_s    = borrow_r;
    sel_nx_s       = sel_r;
    err_nx_s       = err_r;
    p_we_s         = 1'b0;
    p_waddr_s      = wcnt_r;
    d_we_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.res_push_i) begin
          p_we_s         = 1'b1;
          p_waddr_s      = CNT_ZERO;
          wcnt_nx_s      = CNT_ONE;
          last_seen_nx_s = last_seen_r | bus.last_i;
          state_nx_s     = CAPTURE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CAPTURE: begin
        last_seen_nx_s = last_seen_r | bus.last_i;
        if (bus.res_push_i) begin
          p_we_s    = 1'b1;
          wcnt_nx_s = wcnt_r + CNT_ONE;
          if (wcnt_r == CNT_S) begin
            state_nx_s  = SUB;
            k_nx_s      = CNT_ZERO;
            borrow_nx_s = 1'b0;
            err_nx_s    = err_r | ~last_seen_r;
          end else begin
            state_nx_s = CAPTURE;
          end
        end else begin
          state_nx_s = CAPTURE;
        end
      end
      SUB: begin
        err_nx_s = err_r | bus.res_push_i;
        if (k_r != CNT_ZERO) begin
          d_we_s      = 1'b1;
          borrow_nx_s = bout_s;
        end else begin
          borrow_nx_s = 1'b0;
        end
        if (k_r == CNT_S1) begin
          sel_nx_s   = ~bout_s;
          rcnt_nx_s  = CNT_ZERO;
          state_nx_s = OUT;
        end else begin
          k_nx_s = k_r + CNT_ONE;
        end
      end
      OUT: begin
        err_nx_s = err_r | bus.res_push_i;
        if (hs_s && (rcnt_r == CNT_S)) begin
          state_nx_s     = IDLE;
          wcnt_nx_s      = CNT_ZERO;
          rcnt_nx_s      = CNT_ZERO;
          last_seen_nx_s = 1'b0;
        end else if (hs_s) begin
          rcnt_nx_s = rcnt_r + CNT_ONE;
        end else begin
          rcnt_nx_s = rcnt_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // registered outputs are computed from the next state so they line up with it
  always_comb begin
    n_rd_nx_s      = (state_nx_s == SUB) && (k_nx_s < CNT_S);
    n_addr_nx_s    = {AW{1'b0}};
    out_nx_s       = {BLK_W{1'b0}};
    out_valid_nx_s = (state_nx_s == OUT);
    out_last_nx_s  = 1'b0;
    busy_nx_s      = (state_nx_s != IDLE);
    if (n_rd_nx_s) begin
      n_addr_nx_s = k_nx_s[AW-1:0];
    end else begin
      n_addr_nx_s = {AW{1'b0}};
    end
    if (state_nx_s == OUT) begin
      out_nx_s      = sel_nx_s ? d_mem_r[rcnt_nx_s] : p_mem_r[rcnt_nx_s];
      out_last_nx_s = (rcnt_nx_s == CNT_S);
    end else begin
      out_nx_s      = {BLK_W{1'b0}};
      out_last_nx_s = 1'b0;
    end
  end

  // state, counters, flags and output registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r     <= IDLE;
      wcnt_r      <= CNT_ZERO;
      k_r         <= CNT_ZERO;
      rcnt_r      <= CNT_ZERO;
      last_seen_r <= 1'b0;
      borrow_r    <= 1'b0;
      sel_r       <= 1'b0;
      err_r       <= 1'b0;
      n_addr_r    <= {AW{1'b0}};
      n_rd_r      <= 1'b0;
      out_r       <= {BLK_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      wcnt_r      <= wcnt_nx_s;
      k_r         <= k_nx_s;
      rcnt_r      <= rcnt_nx_s;
      last_seen_r <= last_seen_nx_s;
      borrow_r    <= borrow_nx_s;
      sel_r       <= sel_nx_s;
      err_r       <= err_nx_s;
      n_addr_r    <= n_addr_nx_s;
      n_rd_r      <= n_rd_nx_s;
      out_r       <= out_nx_s;
      out_valid_r <= out_valid_nx_s;
      out_last_r  <= out_last_nx_s;
      busy_r      <= busy_nx_s;
    end
  end

  // buffers carry no reset: every entry is written before the FSM can read it
  always_ff @(posedge clock_i) begin
    if (p_we_s) begin
      p_mem_r[p_waddr_s] <= bus.res_i;
    end
    if (d_we_s) begin
      d_mem_r[sub_idx_s] <= diff_s;
    end
  end

  assign bus.n_addr_o    = n_addr_r;
  assign bus.n_rd_o      = n_rd_r;
  assign bus.out_o       = out_r;
  assign bus.out_valid_o = out_valid_r;
  assign bus.out_last_o  = out_last_r;
  assign busy_o          = busy_r;
  assign err_o           = err_r;
endmodule

// File: tb/tb_fios_res_collect.sv
// Self-checking bench for fios_res_collect with s = 2, against a whole-number reference model.
module tb_fios_res_collect;
  import fios_pkg::*;

  localparam int S   = 2;
  localparam int LAT = S + 3;
  typedef logic [S:0][BLK_W-1:0]   res_t;
  typedef logic [S-1:0][BLK_W-1:0] mod_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  mod_t n_mem  = '0;

  fios_res_collect_if #(.s(S)) bus ();

  fios_res_collect #(.s(S)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus),
    .busy_o  (busy),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  // operand memory: data one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    if (bus.n_rd_o && (bus.n_addr_o < S)) bus.n_i <= n_mem[bus.n_addr_o];
    else bus.n_i <= BLK_W'($urandom);
  end

  always @(posedge clk) begin
    if (bus.out_valid_o && bus.out_ready_i) hs_cnt <= hs_cnt + 1;
  end

  // reduced value of P modulo one conditional subtraction of n
  function automatic res_t ref_result(input res_t p, input mod_t n);
    logic [(S+1)*BLK_W-1:0] pv, nv;
    pv = p;
    nv = {{BLK_W{1'b0}}, n};
    if (pv >= nv) return res_t'(pv - nv);
    else return p;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_blocks(input res_t p, input logic with_last);
    for (int i = 0; i <= S; i++) begin
      bus.res_i      = p[i];
      bus.res_push_i = 1'b1;
      bus.last_i     = with_last && (i == S - 1);
      @(negedge clk);
    end
    bus.res_push_i = 1'b0;
    bus.last_i     = 1'b0;
    bus.res_i      = BLK_W'($urandom);
  endtask

  task automatic collect(input int extra_at, input int stall_blk, input int stall_cyc,
                         output res_t got, output logic [S:0] got_last, output int lat,
                         output int bad, output logic timed_out);
    blk_t held;
    logic held_last;
    got = '0; got_last = '0; bad = 0; timed_out = 1'b0; lat = 1;
    while (!bus.out_valid_o && lat < 40) begin
      bus.res_push_i = (lat == extra_at);
      bus.res_i      = BLK_W'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.res_push_i = 1'b0;
    if (!bus.out_valid_o) begin
      timed_out = 1'b1;
      return;
    end
    for (int i = 0; i <= S; i++) begin
      if (i == stall_blk) begin
        bus.out_ready_i = 1'b0;
        held = bus.out_o;
        held_last = bus.out_last_o;
        for (int c = 0; c < stall_cyc; c++) begin
          @(negedge clk);
          if (!bus.out_valid_o || bus.out_o !== held || bus.out_last_o !== held_last) bad++;
        end
      end
      if (!bus.out_valid_o) bad++;
      got[i] = bus.out_o;
      got_last[i] = bus.out_last_o;
      bus.out_ready_i = 1'b1;
      @(negedge clk);
    end
    bus.out_ready_i = 1'b0;
  endtask

  task automatic run_txn(input res_t p, input mod_t n, input logic with_last, input int extra_at,
                         input int stall_blk, input int stall_cyc, output res_t got,
                         output logic [S:0] got_last, output int lat, output int bad,
                         output logic timed_out);
    n_mem = n;
    push_blocks(p, with_last);
    collect(extra_at, stall_blk, stall_cyc, got, got_last, lat, bad, timed_out);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, err} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_err: got %b want 00", {busy, err});
    end
    checks++;
    if ({bus.out_valid_o, bus.out_last_o, bus.n_rd_o} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b want 000", {bus.out_valid_o, bus.out_last_o, bus.n_rd_o});
    end
    checks++;
    if (bus.n_addr_o !== 2'd0 || bus.out_o !== 17'h0) begin
      errors++; $display("FAIL reset_data: addr %0d out %h want 0 0", bus.n_addr_o, bus.out_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_p_ge_n();
    res_t got; logic [S:0] gl; int lat, bad; logic to;
    run_txn({17'h00000, 17'h00003, 17'h00005}, {17'h00001, 17'h00002}, 1'b1, -1, -1, 0, got, gl, lat, bad, to);
    checks++;
    if (to !== 1'b0 || got !== {17'h00000, 17'h00002, 17'h00003}) begin
      errors++; $display("FAIL ge_data: got %h timeout %b want %h", got, to, {17'h00000, 17'h00002, 17'h00003});
    end
    checks++;
    if (gl !== 3'b100) begin errors++; $display("FAIL ge_last: got %b want 100", gl); end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL ge_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      errors++; $display("FAIL ge_idle: err %b busy %b valid %b want 0 0 0", err, busy, bus.out_valid_o);
    end
  endtask

  task automatic test_p_lt_n();
    res_t got; logic [S:0] gl; int lat, bad; logic to;
    run_txn({17'h00000, 17'h00001, 17'h00001}, {17'h00001, 17'h00002}, 1'b1, -1, -1, 0, got, gl, lat, bad, to);
    checks++;
    if (to !== 1'b0 || got !== {17'h00000, 17'h00001, 17'h00001}) begin
      errors++; $display("FAIL lt_data: got %h timeout %b want %h", got, to, {17'h00000, 17'h00001, 17'h00001});
    end
    checks++;
    if (gl !== 3'b100 || err !== 1'b0) begin errors++; $display("FAIL lt_last_err: last %b err %b want 100 0", gl, err); end
  endtask

  task automatic test_borrow_chain();
    res_t got; logic [S:0] gl; int lat, bad; logic to;
    run_txn({17'h00001, 17'h00000, 17'h00000}, {17'h00000, 17'h00001}, 1'b1, -1, -1, 0, got, gl, lat, bad, to);
    checks++;
    if (to !== 1'b0 || got !== {17'h00000, 17'h1FFFF, 17'h1FFFF}) begin
      errors++; $display("FAIL borrow_data: got %h timeout %b want %h", got, to, {17'h00000, 17'h1FFFF, 17'h1FFFF});
    end
  endtask

  task automatic test_random();
    res_t p, got; mod_t n; logic [S:0] gl; int lat, bad; logic to;
    for (int t = 0; t < 10; t++) begin
      n[0] = BLK_W'($urandom);
      n[1] = BLK_W'($urandom_range(1, 17'h1FFFF));
      p[0] = BLK_W'($urandom);
      p[1] = BLK_W'($urandom);
      p[2] = BLK_W'($urandom_range(0, 1));
      run_txn(p, n, 1'b1, -1, -1, 0, got, gl, lat, bad, to);
      checks++;
      if (to !== 1'b0 || got !== ref_result(p, n)) begin
        errors++; $display("FAIL random_data[%0d]: got %h want %h (p %h n %h)", t, got, ref_result(p, n), p, n);
      end
      checks++;
      if (gl !== 3'b100 || lat !== LAT || err !== 1'b0) begin
        errors++; $display("FAIL random_ctl[%0d]: last %b lat %0d err %b want 100 %0d 0", t, gl, lat, err, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t p, got; mod_t n; logic [S:0] gl; int lat, bad, hs0; logic to;
    n = {17'h0F00F, 17'h12345};
    p = {17'h00001, 17'h00F00, 17'h00042};
    hs0 = hs_cnt;
    run_txn(p, n, 1'b1, -1, 1, 3, got, gl, lat, bad, to);
    checks++;
    if (to !== 1'b0 || got !== ref_result(p, n)) begin
      errors++; $display("FAIL bp_data: got %h want %h", got, ref_result(p, n));
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_stable: unstable cycles %0d want 0", bad); end
    @(negedge clk);
    checks++;
    if (hs_cnt - hs0 !== 3 || bus.out_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_handshakes: got %0d valid %b want 3 0", hs_cnt - hs0, bus.out_valid_o);
    end
  endtask

  task automatic test_err_no_last();
    res_t p, got; mod_t n; logic [S:0] gl; int lat, bad; logic to;
    apply_reset();
    n = {17'h00100, 17'h00007};
    p = {17'h00000, 17'h00200, 17'h00003};
    run_txn(p, n, 1'b0, -1, -1, 0, got, gl, lat, bad, to);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL nolast_err: got %b want 1", err); end
    checks++;
    if (to !== 1'b0 || got !== ref_result(p, n)) begin
      errors++; $display("FAIL nolast_data: got %h want %h", got, ref_result(p, n));
    end
    run_txn(p, n, 1'b1, -1, -1, 0, got, gl, lat, bad, to);
    checks++;
    if (err !== 1'b1 || got !== ref_result(p, n)) begin
      errors++; $display("FAIL nolast_sticky: err %b data %h want 1 %h", err, got, ref_result(p, n));
    end
  endtask

  task automatic test_err_push_in_sub();
    res_t p, got; mod_t n; logic [S:0] gl; int lat, bad; logic to;
    apply_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL subpush_pre: err %b want 0", err); end
    n = {17'h1ABCD, 17'h00011};
    p = {17'h00001, 17'h00022, 17'h00033};
    run_txn(p, n, 1'b1, 2, -1, 0, got, gl, lat, bad, to);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL subpush_err: got %b want 1", err); end
    checks++;
    if (to !== 1'b0 || got !== ref_result(p, n) || lat !== LAT) begin
      errors++; $display("FAIL subpush_data: got %h lat %0d want %h %0d", got, lat, ref_result(p, n), LAT);
    end
  endtask

  task automatic test_async_reset_mid_sub();
    res_t p, got; mod_t n; logic [S:0] gl; int lat, bad; logic to;
    n_mem = {17'h00003, 17'h00004};
    push_blocks({17'h00001, 17'h00005, 17'h00006}, 1'b1);
    checks++;
    if (busy !== 1'b1 || bus.n_rd_o !== 1'b1) begin
      errors++; $display("FAIL arst_pre: busy %b n_rd %b want 1 1", busy, bus.n_rd_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, err, bus.n_rd_o, bus.out_valid_o, bus.out_last_o} !== 5'b00000 || bus.n_addr_o !== 2'd0 || bus.out_o !== 17'h0) begin
      errors++; $display("FAIL arst_now: busy %b err %b n_rd %b valid %b want all 0", busy, err, bus.n_rd_o, bus.out_valid_o);
    end
    #4 rst_n = 1'b1;
    @(negedge clk);
    n = {17'h00020, 17'h00010};
    p = {17'h00000, 17'h00030, 17'h00011};
    run_txn(p, n, 1'b1, -1, -1, 0, got, gl, lat, bad, to);
    checks++;
    if (to !== 1'b0 || got !== ref_result(p, n) || gl !== 3'b100 || err !== 1'b0) begin
      errors++; $display("FAIL arst_fresh: got %h last %b err %b want %h 100 0", got, gl, err, ref_result(p, n));
    end
  endtask

  initial begin
    bus.res_i = '0; bus.res_push_i = 1'b0; bus.last_i = 1'b0; bus.out_ready_i = 1'b0;
    test_reset();
    test_p_ge_n();
    test_p_lt_n();
    test_borrow_chain();
    test_random();
    test_backpressure();
    test_err_no_last();
    test_err_push_in_sub();
    test_async_reset_mid_sub();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
